// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential 32-bit signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-and-subtract step on unsigned magnitudes (combinational).
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // The extra top bit keeps a shifted remainder near 2^(WIDTH-1) from aliasing negative.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign w_fits  = ~w_trial[WIDTH];

  assign o_rem = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_32_seq.sv
// Multicycle signed divider: 32 restoring steps on magnitudes, then one sign-fix cycle.
module div_32_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exc;
  logic             r_rdy;
  logic             r_busy;

  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  // -2^31 maps to 0x80000000, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? f_neg(v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem),
    .o_quo     (w_quo)
  );

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_div       <= {WIDTH{1'b0}};
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_exc       <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_DIV && (data_operandB == {WIDTH{1'b0}})) begin
            r_result    <= {WIDTH{1'b0}};
            r_remainder <= {WIDTH{1'b0}};
            r_exc       <= 1'b1;
            r_rdy       <= 1'b1;
            r_busy      <= 1'b1;
          end else if (ctrl_DIV) begin
            r_quo    <= f_abs(data_operandA);
            r_div    <= f_abs(data_operandB);
            r_rem    <= {WIDTH{1'b0}};
            r_sign_a <= data_operandA[WIDTH-1];
            r_sign_b <= data_operandB[WIDTH-1];
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
            r_state  <= S_BUSY;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_BUSY: begin
          r_rem  <= w_rem;
          r_quo  <= w_quo;
          r_cnt  <= r_cnt + CNT_W'(1);
          r_busy <= 1'b1;
          if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_FIX: begin
          r_result    <= (r_sign_a ^ r_sign_b) ? f_neg(r_quo) : r_quo;
          r_remainder <= r_sign_a ? f_neg(r_rem) : r_rem;
          r_exc       <= 1'b0;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: vector table, random vs arithmetic model, corner sequences.
module tb_div_32_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        ctrl;
  logic [31:0] res;
  logic [31:0] rem;
  logic        exc;
  logic        rdy;
  logic        bsy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  div_32_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_DIV       (ctrl),
    .data_result    (res),
    .data_remainder (rem),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (bsy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; e = 1'b0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
      e = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present operands and strobe through one edge (E0), then scramble the operands.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    opa  = a;
    opb  = b;
    ctrl = 1'b1;
    tick();
    ctrl = 1'b0;
    opa  = $urandom;
    opb  = $urandom;
  endtask

  task automatic wait_rdy(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!rdy && lat < 40) begin
      if (!bsy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (!bsy) busy_ok = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input logic e);
    int   lat;
    logic ok;
    launch(a, b);
    wait_rdy(lat, ok);
    check({tag, "_latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd33);
    check({tag, "_result"}, res, q);
    check({tag, "_remainder"}, rem, r);
    check({tag, "_exception"}, {31'd0, exc}, {31'd0, e});
    check({tag, "_busy_during"}, {31'd0, ok}, 32'd1);
    tick();
    check({tag, "_rdy_pulse_end"}, {31'd0, rdy}, 32'd0);
    check({tag, "_busy_after"}, {31'd0, bsy}, 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          lat;
    int          n;
    int          rdy_cnt;
    int          first;
    int          second;
    logic        ok;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{-32'sd100,      32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2] = '{32'd100,        -32'sd7,        32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3] = '{32'd55,         32'd0,          32'd0,          32'd0,          1'b1};
    vecs[4] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    vecs[7] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    vecs[8] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};

    reset_n = 1'b0;
    ctrl    = 1'b0;
    opa     = 32'd0;
    opb     = 32'd0;
    tick();
    tick();
    check("reset_result", res, 32'd0);
    check("reset_remainder", rem, 32'd0);
    check("reset_flags", {29'd0, exc, rdy, bsy}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e);
    end

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(0, 20)) - 32'd10;
      if (i % 5 == 2) a = 32'($urandom_range(0, 1000)) - 32'd500;
      model(a, b, q, r, e);
      run_check($sformatf("rand%0d", i), a, b, q, r, e);
    end

    // A start strobe while busy must be ignored entirely.
    launch(32'd1000, 32'd10);
    n = 0; rdy_cnt = 0; first = 0; q = 32'd0;
    repeat (70) begin
      if (n == 10) begin opa = 32'd5; opb = 32'd5; ctrl = 1'b1; end
      if (n == 11) ctrl = 1'b0;
      tick();
      n++;
      if (rdy) begin
        rdy_cnt++;
        if (first == 0) begin first = n; q = res; end
      end
    end
    check("ignore_rdy_count", 32'(rdy_cnt), 32'd1);
    check("ignore_rdy_cycle", 32'(first), 32'd33);
    check("ignore_result", q, 32'd100);

    // Start accepted on the ready cycle; old outputs hold until the new completion.
    launch(32'd1000, 32'd10);
    wait_rdy(lat, ok);
    check("b2b_first_result", res, 32'd100);
    opa = 32'd50; opb = 32'd7; ctrl = 1'b1;
    tick();
    ctrl = 1'b0;
    check("b2b_rdy_low", {31'd0, rdy}, 32'd0);
    check("b2b_hold_result", res, 32'd100);
    check("b2b_busy", {31'd0, bsy}, 32'd1);
    wait_rdy(lat, ok);
    check("b2b_latency", 32'(lat), 32'd33);
    check("b2b_result", res, 32'd7);
    check("b2b_remainder", rem, 32'd1);
    tick();

    // Continuous strobe: back-to-back divisions with no idle gap.
    opa = 32'd20; opb = 32'd4; ctrl = 1'b1;
    tick();
    n = 0; first = 0; second = 0;
    repeat (70) begin
      tick();
      n++;
      if (rdy && first == 0) first = n;
      else if (rdy && second == 0) second = n;
    end
    ctrl = 1'b0;
    check("cont_first_rdy", 32'(first), 32'd33);
    check("cont_second_rdy", 32'(second), 32'd67);
    check("cont_result", res, 32'd5);
    wait_rdy(lat, ok);
    tick();

    // Reset mid-operation clears outputs at once and suppresses the ready pulse.
    launch(32'd1000, 32'd10);
    repeat (14) tick();
    reset_n = 1'b0;
    #1;
    check("rst_result", res, 32'd0);
    check("rst_remainder", rem, 32'd0);
    check("rst_flags", {29'd0, exc, rdy, bsy}, 32'd0);
    tick();
    reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      tick();
      if (rdy) rdy_cnt++;
    end
    check("rst_no_rdy", 32'(rdy_cnt), 32'd0);
    run_check("rst_restart", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_32_seq.md
Name: div_32_seq

Overview:
- Multicycle signed 32-bit integer divider; the processor's multdiv path uses it for DIV.
- Uses shift-and-subtract: one restoring step per cycle on operand magnitudes, then a sign-correction cycle.
- Operands are latched on a one-cycle start strobe.
- Result and exception appear with a single-cycle ready pulse. The pipeline stalls until that pulse.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified)
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clock  in  1  single design clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset; forces IDLE and clears all outputs/registers
- data_operandA  in  WIDTH  dividend, two's complement, sampled only on the accepted start
- data_operandB  in  WIDTH  divisor, two's complement, sampled only on the accepted start
- ctrl_DIV  in  1  start strobe; accepted only in IDLE
- data_result  out  WIDTH  signed quotient, truncated toward zero; held until next accepted start
- data_remainder  out  WIDTH  signed remainder, sign of dividend; held likewise
- data_exception  out  1  divide-by-zero flag, valid with data_resultRDY, held likewise
- data_resultRDY  out  1  one-cycle pulse: result/remainder/exception valid
- busy  out  1  high from the accepted start until the ready pulse inclusive

Behaviour:
- Reset values (async assertion, deasserted synchronously to clock by system):
  - data_result = 0, data_remainder = 0, data_exception = 0, data_resultRDY = 0, busy = 0
  - state = IDLE, counter = 0
- States: IDLE, BUSY, FIX.
- IDLE:
  - ctrl_DIV = 1 at edge E0 with B != 0 → latch |A|, |B|, signA, signB, quotient = |A|, partial remainder = 0, counter = 0 → BUSY.
  - ctrl_DIV = 1 with B == 0 → stay IDLE. At E0 drive data_result = 0, data_remainder = 0, data_exception = 1, data_resultRDY = 1 (pulse in the cycle after E0).
- BUSY, one step per edge:
  - Shift {rem, quo} left 1.
  - Trial = rem − |B| (WIDTH+1 bits).
  - If trial ≥ 0: rem = trial, quo[0] = 1; else quo[0] = 0.
  - Counter increments each step; after the 32nd step (edge E32) → FIX.
- FIX (edge E33):
  - data_result = (signA ^ signB) ? −quo : quo
  - data_remainder = signA ? −rem : rem
  - data_exception = 0, data_resultRDY = 1 for the following cycle only, → IDLE.
- Latency: ready visible in the cycle after E33 (33 cycles after start) for B != 0; 1 cycle for B == 0.
- Magnitude of −2^31 is taken as unsigned 0x80000000 (WIDTH-bit unsigned datapath).
- −2^31 / −1 → quotient 0x80000000 (wraps), remainder 0, exception 0.
- Arithmetic is modulo 2^WIDTH.
- ctrl_DIV while BUSY or FIX: ignored entirely; no queuing and no restart.
- ctrl_DIV in the same cycle the ready pulse is visible (state IDLE): accepted normally. Outputs keep old values until the new completion.
- ctrl_DIV held high continuously: a new division starts at every IDLE edge, back-to-back.
- Operand inputs may change freely after the start edge without effect.
- Reset mid-operation: immediate return to IDLE, no ready pulse, all outputs zeroed. The next start behaves as from power-up.
- busy is a registered output: busy = (state != IDLE) or data_resultRDY.

Decomposition:
- Shared package div_pkg:
  - state encoding constants S_IDLE = 2'd0, S_BUSY = 2'd1, S_FIX = 2'd2
  - DIV_WIDTH = 32, DIV_ITERS = 32
- Sub-module div_step (combinational).
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Contains the WIDTH+1-bit trial subtract and select.
  - Instantiated once in the BUSY datapath.
  - Unit-testable standalone against the same trial-subtract rule.

Test Plan:
- A = 100, B = 7, pulse ctrl_DIV → rdy exactly 33 cycles later; result 14, remainder 2, exception 0; busy high throughout.
- A = −100, B = 7 → result −14 (0xFFFFFFF2), remainder −2; A = 100, B = −7 → result −14, remainder 2.
- A = 55, B = 0 → rdy 1 cycle later; exception 1, result 0, remainder 0. Next division A = 9, B = 3 → result 3, exception 0.
- A = 0x80000000, B = 0xFFFFFFFF → result 0x80000000, remainder 0. A = 0x80000000, B = 1 → result 0x80000000.
- Start A = 1000, B = 10, then pulse ctrl_DIV with A = 5, B = 5 at cycle 10 → only one rdy, at cycle 33, result 100. Back-to-back start on the rdy cycle gives a second rdy 33 cycles later.
- Start A = 1000, B = 10, assert reset_n = 0 at cycle 15 → outputs 0 immediately, no rdy. Restart A = 81, B = 9 → result 9 after 33 cycles.
